pipe_skid_reg: RTL

Parametrised pipeline stage register that succeeds the fixed-width stage latches between CPU pipeline stages (e.g. MEM->WB).
- Data and control fields have configurable widths.
- Adds a valid/ready handshake backed by a 2-entry skid buffer, so backpressure never drops or duplicates an instruction.
- Adds a synchronous flush that inserts a bubble (control zeroed), and a saturating stall-cycle counter for performance debug.
- Sits between any two pipeline stages; the upstream stage drives in_*, the downstream stage drives out_ready.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/sat_counter.sv | 37 +++
 rtl/pipe_skid_reg.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: occupancy states, per-stage
// payload widths and control-bit positions.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam int MEMWB_DATA_W = 69;
    localparam int MEMWB_CTRL_W = 2;

    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high reset; sticks at all-ones.
module sat_counter
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = sat_inc(count_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake backed by a two-entry
// skid buffer, synchronous flush (bubble insertion) and a stall-cycle counter.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = MEMWB_DATA_W,
    parameter int CTRL_W = MEMWB_CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_e            state_q,     state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              in_ready_q,  in_ready_d;

    logic in_fire;
    logic out_fire;
    logic main_valid;

    assign main_valid = (state_q != EMPTY);
    assign in_fire    = in_valid & in_ready_q;
    assign out_fire   = main_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        if (flush) begin
            // Bubble: anything arriving this cycle is dropped along with both slots.
            state_d     = EMPTY;
            main_data_d = '0;
            main_ctrl_d = '0;
            skid_data_d = '0;
            skid_ctrl_d = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d     = BUSY;
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (in_fire) begin
                        state_d     = FULL;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end else if (out_fire) begin
                        // Data is left in place so out_data holds its last value.
                        state_d     = EMPTY;
                        main_ctrl_d = '0;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain side can move.
                    if (out_fire) begin
                        state_d     = BUSY;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        skid_ctrl_d = '0;
                    end
                end
                default: begin
                    state_d     = EMPTY;
                    main_ctrl_d = '0;
                end
            endcase
        end
    end

    assign in_ready_d = (state_d != FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_valid ? main_ctrl_q : '0;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (main_valid & ~out_ready),
        .count (stall_cnt)
    );

endmodule
